// File: rtl/life_pkg.sv
// Shared constants, FSM state type and grid indexing helpers for the Game-of-Life engine.
package life_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int GW   = COLS + 2;
    localparam int NB   = GW * (ROWS + 2);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        COMMIT
    } state_t;

    function automatic int cell_bit(input int r, input int c);
        return (r + 1) * GW + (c + 1);
    endfunction

    function automatic logic [NB-1:0] vis_mask_f();
        logic [NB-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                m[cell_bit(r, c)] = 1'b1;
            end
        end
        return m;
    endfunction

    // Ones on visible cells, zeros on the dead border ring.
    localparam logic [NB-1:0] VIS_MASK = vis_mask_f();

endpackage

// File: rtl/life_cell_rule.sv
// B3/S23 rule for one cell: 3x3 neighbourhood in (centre at bit 4), next state out.
// Purely combinational.
module life_cell_rule (
    input  logic [8:0] i_nbhd,
    output logic       o_alive
);

    logic [3:0] w_n;

    always_comb begin
        w_n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                w_n = w_n + {3'd0, i_nbhd[i]};
            end
        end
    end

    assign o_alive = (w_n == 4'd3) | (i_nbhd[4] & (w_n == 4'd2));

endmodule

// File: rtl/life_step_engine.sv
// Sequential Game-of-Life generation engine: snapshots the bordered grid, evaluates one cell per clock,
// streams each result to frame memory, then commits the next generation with status flags (start->done 67 cycles).
module life_step_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [(COLS+2)*(ROWS+2)-1:0]    grid_in,
    output logic                            busy,
    output logic                            done,
    output logic [(COLS+2)*(ROWS+2)-1:0]    grid_out,
    output logic                            wr_en,
    output logic [5:0]                      wr_addr,
    output logic                            wr_alive,
    output logic [GEN_W-1:0]                generation,
    output logic [6:0]                      alive_count,
    output logic                            extinct,
    output logic                            still
);

    import life_pkg::*;

    localparam int GW = COLS + 2;
    localparam int NB = GW * (ROWS + 2);
    localparam int IW = $clog2(NB);
    localparam logic [5:0] LAST_IDX = 6'(ROWS * COLS - 1);

    state_t            r_state, w_state_nxt;
    logic [NB-1:0]     r_snap, r_work, r_grid_out, w_vis_mask;
    logic [5:0]        r_idx;
    logic [6:0]        r_cnt, r_alive_count;
    logic [GEN_W-1:0]  r_gen;
    logic              r_done, r_wr_en, r_wr_alive, r_extinct, r_still;
    logic [5:0]        r_wr_addr;
    logic [8:0]        w_nbhd;
    logic [IW-1:0]     w_cell;
    logic              w_alive_nxt;

    always_comb begin
        w_vis_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_vis_mask[IW'((r + 1) * GW + c + 1)] = 1'b1;
            end
        end
    end

    // The window's top-left corner in bordered coordinates equals the visible (r,c) of the cell.
    always_comb begin
        int base;
        base   = (int'(r_idx) / COLS) * GW + (int'(r_idx) % COLS);
        w_nbhd = '0;
        for (int dr = 0; dr < 3; dr++) begin
            for (int dc = 0; dc < 3; dc++) begin
                w_nbhd[dr*3 + dc] = r_snap[IW'(base + dr * GW + dc)];
            end
        end
        w_cell = IW'(base + GW + 1);
    end

    life_cell_rule u_rule (
        .i_nbhd  (w_nbhd),
        .o_alive (w_alive_nxt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = SCAN;
            SCAN:    if (r_idx == LAST_IDX) w_state_nxt = COMMIT;
            COMMIT:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap        <= '0;
            r_work        <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_grid_out    <= '0;
            r_alive_count <= '0;
            r_extinct     <= 1'b0;
            r_still       <= 1'b0;
            r_gen         <= '0;
            r_done        <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_alive    <= 1'b0;
        end else begin
            r_done     <= (r_state == COMMIT);
            r_wr_en    <= (r_state == SCAN);
            r_wr_addr  <= (r_state == SCAN) ? r_idx : 6'd0;
            r_wr_alive <= (r_state == SCAN) & w_alive_nxt;
            case (r_state)
                LOAD: begin
                    r_snap <= grid_in & w_vis_mask;
                    r_work <= '0;
                    r_idx  <= '0;
                    r_cnt  <= '0;
                end
                SCAN: begin
                    r_work[w_cell] <= w_alive_nxt;
                    r_idx          <= r_idx + 6'd1;
                    r_cnt          <= r_cnt + {6'd0, w_alive_nxt};
                end
                COMMIT: begin
                    r_grid_out    <= r_work;
                    r_alive_count <= r_cnt;
                    r_extinct     <= (r_cnt == 7'd0);
                    r_still       <= (r_work == r_snap);
                    r_gen         <= r_gen + {{(GEN_W-1){1'b0}}, 1'b1};
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign grid_out    = r_grid_out;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_alive    = r_wr_alive;
    assign generation  = r_gen;
    assign alive_count = r_alive_count;
    assign extinct     = r_extinct;
    assign still       = r_still;

endmodule

// File: tb/tb_life_step_engine.sv
// Directed bench for life_step_engine: table of patterns with hand-computed next generations,
// plus sequences for ignored starts, back-to-back starts and reset mid-scan.
module tb_life_step_engine;

    localparam int NB    = life_pkg::NB;
    localparam int GEN_W = 16;

    typedef struct {
        string         name;
        logic [NB-1:0] grid;
        logic [NB-1:0] expg;
        logic [6:0]    cnt;
        logic          ext;
        logic          stl;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [NB-1:0]     grid_in = '0;
    logic              busy, done, wr_en, wr_alive, extinct, still;
    logic [NB-1:0]     grid_out;
    logic [5:0]        wr_addr;
    logic [GEN_W-1:0]  generation;
    logic [6:0]        alive_count;

    int                n_chk = 0;
    int                n_err = 0;
    logic [GEN_W-1:0]  exp_gen = '0;
    vec_t              tbl[8];

    life_step_engine #(.ROWS(8), .COLS(8), .GEN_W(GEN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .grid_in     (grid_in),
        .busy        (busy),
        .done        (done),
        .grid_out    (grid_out),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_alive    (wr_alive),
        .generation  (generation),
        .alive_count (alive_count),
        .extinct     (extinct),
        .still       (still)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] mk(input int b0, input int b1, input int b2, input int b3);
        logic [NB-1:0] g;
        g = '0;
        if (b0 >= 0) g[b0] = 1'b1;
        if (b1 >= 0) g[b1] = 1'b1;
        if (b2 >= 0) g[b2] = 1'b1;
        if (b3 >= 0) g[b3] = 1'b1;
        return g;
    endfunction

    // Runs one generation. pre: start was already captured by the previous run.
    // chain: issue the next start (with grid nxt) in the done cycle.
    task automatic run_gen(input vec_t v, input bit inject, input bit pre, input bit chain,
                           input logic [NB-1:0] nxt);
        int            n_done, done_cyc, n_wr, n_bad, last;
        logic [NB-1:0] s_grid;
        logic [6:0]    s_cnt;
        logic          s_ext, s_stl, s_busy;
        logic [GEN_W-1:0] s_gen;
        n_done = 0; done_cyc = 0; n_wr = 0; n_bad = 0;
        s_grid = '0; s_cnt = '0; s_ext = 1'b0; s_stl = 1'b0; s_busy = 1'b1; s_gen = '0;
        last = chain ? 67 : 70;
        if (!pre) begin
            grid_in = v.grid;
            start   = 1'b1;
            @(posedge clk); #1;
        end
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (cyc == 1) chk({v.name, " busy_load"}, busy, 1'b1);
            if (cyc == 2) grid_in = ~v.grid;
            if (wr_en) begin
                if (wr_addr !== 6'(n_wr)) n_bad++;
                else if (wr_alive !== v.expg[life_pkg::cell_bit(n_wr / 8, n_wr % 8)]) n_bad++;
                n_wr++;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 67) begin
                s_grid = grid_out; s_cnt = alive_count; s_ext = extinct;
                s_stl = still; s_busy = busy; s_gen = generation;
            end
            if (inject && (cyc == 10 || cyc == 40)) start = 1'b1;
            if (chain && cyc == 67) begin
                grid_in = nxt;
                start   = 1'b1;
            end
        end
        if (chain) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        exp_gen = exp_gen + 1'b1;
        chk({v.name, " latency"},     done_cyc, 67);
        chk({v.name, " done_pulses"}, n_done, 1);
        chk({v.name, " wr_strobes"},  n_wr, 64);
        chk({v.name, " wr_stream"},   n_bad, 0);
        chk({v.name, " grid_out"},    s_grid, v.expg);
        chk({v.name, " alive_count"}, s_cnt, v.cnt);
        chk({v.name, " extinct"},     s_ext, v.ext);
        chk({v.name, " still"},       s_stl, v.stl);
        chk({v.name, " generation"},  s_gen, exp_gen);
        chk({v.name, " busy_done"},   s_busy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{"blinker_h", mk(43, 44, 45, -1), mk(34, 44, 54, -1), 7'd3, 1'b0, 1'b0};
        tbl[1] = '{"block", mk(55, 56, 65, 66), mk(55, 56, 65, 66), 7'd4, 1'b0, 1'b1};
        tbl[2] = '{"lone", mk(44, -1, -1, -1), '0, 7'd0, 1'b1, 1'b0};
        tbl[3] = '{"border", mk(55, 56, 65, 66) | mk(0, 9, 90, 99), mk(55, 56, 65, 66), 7'd4, 1'b0, 1'b1};
        tbl[4] = '{"blinker_v", mk(34, 44, 54, -1), mk(43, 44, 45, -1), 7'd3, 1'b0, 1'b0};
        tbl[5] = '{"corner_tl", mk(11, 12, 21, -1), mk(11, 12, 21, 22), 7'd4, 1'b0, 1'b0};
        tbl[6] = '{"corner_br", mk(77, 78, 87, -1), mk(77, 78, 87, 88), 7'd4, 1'b0, 1'b0};
        tbl[7] = '{"empty", '0, '0, 7'd0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst wr_en", wr_en, 1'b0);
        chk("rst grid_out", grid_out, '0);
        chk("rst generation", generation, '0);
        chk("rst alive_count", alive_count, '0);
        chk("rst flags", {extinct, still}, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_gen(tbl[i], 1'b0, 1'b0, 1'b0, '0);
        end

        // Starts pulsed while busy must be dropped.
        run_gen(tbl[0], 1'b1, 1'b0, 1'b0, '0);

        // Back-to-back: a start in the done cycle launches the next pass.
        run_gen(tbl[1], 1'b0, 1'b0, 1'b1, tbl[5].grid);
        run_gen(tbl[5], 1'b0, 1'b1, 1'b0, '0);

        // Reset in the middle of a scan.
        grid_in = tbl[6].grid;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("pre-rst busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst busy", busy, 1'b0);
        chk("midrst done", done, 1'b0);
        chk("midrst wr_en", wr_en, 1'b0);
        chk("midrst grid_out", grid_out, '0);
        chk("midrst generation", generation, '0);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_gen = '0;
        @(posedge clk); #1;
        run_gen(tbl[2], 1'b0, 1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
